// File: rtl/ddr_rd_arbiter_pkg.sv
// Global parameters and shared types for the DDR read arbiter.
package ddr_rd_arbiter_pkg;

  localparam int GP_DDR_W      = 32;
  localparam int GP_DDR_ADDR_W = 32;
  localparam int GP_BURST_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set req bit after index 'last', wrapping.
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] grant,
  output logic          grant_vld
);

  int idx;

  // Walk from farthest to nearest candidate so the nearest one after 'last' wins
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = 0;
    for (int i = N; i >= 1; i--) begin
      idx = (int'(last) + i) % N;
      if (req[idx]) begin
        grant     = idx[IW-1:0];
        grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr_rd_arbiter.sv
// Round-robin arbiter sharing one DDR read channel among REQ_NUM requesters.
// One burst in flight at a time: IDLE (arbitrate) -> ADDR (issue) -> DATA (stream beats).
// Optional DDR_ARB_PERF_EN adds per-requester saturating beat counters on perf_cnt.
module ddr_rd_arbiter
  import ddr_rd_arbiter_pkg::*;
#(
  parameter int REQ_NUM    = 3,
  parameter int DDR_W      = GP_DDR_W,
  parameter int DDR_ADDR_W = GP_DDR_ADDR_W,
  parameter int BURST_W    = GP_BURST_W
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [REQ_NUM-1:0][DDR_ADDR_W-1:0]  req_addr,
  input  logic [REQ_NUM-1:0][BURST_W-1:0]     req_size,
  input  logic [REQ_NUM-1:0]                  req_valid,
  output logic [REQ_NUM-1:0]                  req_ready,
  output logic [DDR_W-1:0]                    rd_data,
  output logic [REQ_NUM-1:0]                  rd_valid,
  input  logic [REQ_NUM-1:0]                  rd_ready,
  output logic [DDR_ADDR_W-1:0]               ddr_in_addr,
  output logic [BURST_W-1:0]                  ddr_in_size,
  output logic                                ddr_in_addr_valid,
  input  logic                                ddr_in_addr_ready,
  input  logic [DDR_W-1:0]                    ddr_in_data,
  input  logic                                ddr_in_valid,
  output logic                                ddr_in_ready,
  output logic                                busy
`ifdef DDR_ARB_PERF_EN
  ,
  output logic [REQ_NUM-1:0][31:0]            perf_cnt
`endif
);

  localparam int IW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

  arb_state_e            state_q, state_d;
  logic [IW-1:0]         grant_q, grant_d;
  logic [IW-1:0]         last_q, last_d;
  logic [DDR_ADDR_W-1:0] addr_q, addr_d;
  logic [BURST_W-1:0]    size_q, size_d;
  logic [BURST_W-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]         arb_grant;
  logic                  arb_vld;
  logic                  beat_hs;

  rr_arbiter #(.N(REQ_NUM)) u_rr (
    .req       (req_valid),
    .last      (last_q),
    .grant     (arb_grant),
    .grant_vld (arb_vld)
  );

  assign beat_hs = (state_q == DATA) && ddr_in_valid && rd_ready[grant_q];

  // Next-state and handshake steering; every output is gated by state so IDLE drives zeros
  always_comb begin
    state_d           = state_q;
    grant_d           = grant_q;
    last_d            = last_q;
    addr_d            = addr_q;
    size_d            = size_q;
    cnt_d             = cnt_q;
    req_ready         = '0;
    rd_valid          = '0;
    rd_data           = '0;
    ddr_in_addr       = '0;
    ddr_in_size       = '0;
    ddr_in_addr_valid = 1'b0;
    ddr_in_ready      = 1'b0;
    busy              = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        // Addr/size are captured only here; later requester changes are ignored
        if (arb_vld) begin
          grant_d = arb_grant;
          addr_d  = req_addr[arb_grant];
          size_d  = req_size[arb_grant];
          state_d = ADDR;
        end
      end
      ADDR: begin
        ddr_in_addr_valid  = 1'b1;
        ddr_in_addr        = addr_q;
        ddr_in_size        = size_q;
        req_ready[grant_q] = ddr_in_addr_ready;
        if (ddr_in_addr_ready) begin
          cnt_d   = size_q;
          state_d = DATA;
        end
      end
      DATA: begin
        rd_data           = ddr_in_data;
        rd_valid[grant_q] = ddr_in_valid;
        ddr_in_ready      = rd_ready[grant_q];
        // Counter holds beats-minus-one, so the zero beat is the last and it never wraps
        if (beat_hs) begin
          if (cnt_q == '0) begin
            last_d  = grant_q;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; last grant resets to the top index so requester 0 wins first
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(REQ_NUM - 1);
      addr_q  <= '0;
      size_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef DDR_ARB_PERF_EN
  logic [REQ_NUM-1:0][31:0] perf_cnt_q, perf_cnt_d;

  // Count accepted beats for the granted requester, sticking at all-ones
  always_comb begin
    perf_cnt_d = perf_cnt_q;
    if (beat_hs && (perf_cnt_q[grant_q] != 32'hFFFF_FFFF))
      perf_cnt_d[grant_q] = perf_cnt_q[grant_q] + 32'd1;
  end

  // Perf counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) perf_cnt_q <= '0;
    else      perf_cnt_q <= perf_cnt_d;
  end

  assign perf_cnt = perf_cnt_q;
`endif

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// Bench for ddr_rd_arbiter: directed table, multi-cycle corner sequences and a
// randomized run checked against a transaction-level model of the arbiter.
module tb_ddr_rd_arbiter;
  import ddr_rd_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int DW = GP_DDR_W;
  localparam int AW = GP_DDR_ADDR_W;
  localparam int BW = GP_BURST_W;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0][AW-1:0] req_addr;
  logic [N-1:0][BW-1:0] req_size;
  logic [N-1:0]         req_valid, req_ready, rd_valid, rd_ready;
  logic [DW-1:0]        rd_data, ddr_in_data;
  logic [AW-1:0]        ddr_in_addr;
  logic [BW-1:0]        ddr_in_size;
  logic                 ddr_in_addr_valid, ddr_in_addr_ready, ddr_in_valid, ddr_in_ready, busy;
`ifdef DDR_ARB_PERF_EN
  logic [N-1:0][31:0]   perf_cnt;
`endif

  always #5 clk = ~clk;

  ddr_rd_arbiter #(.REQ_NUM(N)) dut (
    .clk(clk), .rst(rst),
    .req_addr(req_addr), .req_size(req_size), .req_valid(req_valid), .req_ready(req_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .ddr_in_addr(ddr_in_addr), .ddr_in_size(ddr_in_size),
    .ddr_in_addr_valid(ddr_in_addr_valid), .ddr_in_addr_ready(ddr_in_addr_ready),
    .ddr_in_data(ddr_in_data), .ddr_in_valid(ddr_in_valid), .ddr_in_ready(ddr_in_ready),
    .busy(busy)
`ifdef DDR_ARB_PERF_EN
    , .perf_cnt(perf_cnt)
`endif
  );

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  bit            m_busy, m_addr_done;
  int            m_g, m_last, m_beats_left;
  logic [AW-1:0] m_addr;
  logic [BW-1:0] m_size;
  int            grant_log[$];
  int            beats[N];
  logic [DW-1:0] rx_log[$];
  logic [N-1:0]  acc_q;
  bit            hs_q, busy_seen, auto_drop;
  int            busy_cycles;

  task automatic model_reset();
    m_busy = 0; m_addr_done = 0; m_last = N - 1; m_g = 0; m_beats_left = 0;
    for (int i = 0; i < N; i++) beats[i] = 0;
  endtask

  // Expected outputs follow from who owns the channel and which phase it is in
  task automatic check_outputs();
    logic [N-1:0] e_rr, e_rv;
    logic e_av, e_dr;
    e_rr = '0; e_rv = '0; e_av = 1'b0; e_dr = 1'b0;
    if (m_busy && !m_addr_done) begin
      e_av = 1'b1;
      e_rr[m_g] = ddr_in_addr_ready;
      chk("ddr_addr", ddr_in_addr, m_addr);
      chk("ddr_size", ddr_in_size, m_size);
    end
    if (m_busy && m_addr_done) begin
      e_rv[m_g] = ddr_in_valid;
      e_dr = rd_ready[m_g];
      chk("rd_data", rd_data, ddr_in_data);
    end
    chk("busy", busy, m_busy);
    chk("addr_valid", ddr_in_addr_valid, e_av);
    chk("req_ready", req_ready, e_rr);
    chk("rd_valid", rd_valid, e_rv);
    chk("ddr_in_ready", ddr_in_ready, e_dr);
  endtask

  task automatic model_update();
    if (!m_busy) begin
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (m_last + k) % N;
        if (req_valid[j]) begin
          m_busy = 1; m_addr_done = 0; m_g = j;
          m_addr = req_addr[j]; m_size = req_size[j];
          break;
        end
      end
    end else if (!m_addr_done) begin
      if (ddr_in_addr_ready) begin
        m_addr_done = 1;
        m_beats_left = int'(m_size) + 1;
        grant_log.push_back(m_g);
      end
    end else if (ddr_in_valid && rd_ready[m_g]) begin
      beats[m_g]++;
      m_beats_left--;
      if (m_beats_left == 0) begin
        m_busy = 0;
        m_last = m_g;
      end
    end
  endtask

  // One clock: settle, check, observe, clock edge, advance model
  task automatic tick();
    #1;
    check_outputs();
    acc_q = req_ready;
    hs_q = ddr_in_valid && ddr_in_ready;
    busy_seen = busy;
    if (busy) busy_cycles++;
    for (int i = 0; i < N; i++)
      if (rd_valid[i] && rd_ready[i]) rx_log.push_back(rd_data);
    @(posedge clk);
    model_update();
    #1;
    if (auto_drop) req_valid = req_valid & ~acc_q;
  endtask

  task automatic run_burst(input int maxc);
    bit seen;
    seen = 0;
    for (int c = 0; c < maxc; c++) begin
      tick();
      if (m_busy) seen = 1;
      else if (seen) return;
    end
    checks++; failures++;
    $display("FAIL burst_timeout: burst not finished after %0d cycles", maxc);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_addr_valid"}, ddr_in_addr_valid, 0);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_ddr_in_ready"}, ddr_in_ready, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_ddr_addr"}, ddr_in_addr, 0);
    chk({tag, "_ddr_size"}, ddr_in_size, 0);
`ifdef DDR_ARB_PERF_EN
    for (int i = 0; i < N; i++) chk({tag, "_perf"}, perf_cnt[i], 0);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    model_reset();
    rst = 1'b1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [N-1:0] rv; logic ar; logic dv; logic [N-1:0] rr; logic [DW-1:0] d;
    logic e_busy; logic e_av; logic [N-1:0] e_rdy; logic [N-1:0] e_rv; logic e_dr; logic e_dph;
  } vec_t;

  function automatic vec_t row(input logic [N-1:0] rv, input logic ar, input logic dv,
                               input logic [N-1:0] rr, input logic [DW-1:0] d,
                               input logic e_busy, input logic e_av, input logic [N-1:0] e_rdy,
                               input logic [N-1:0] e_rv, input logic e_dr, input logic e_dph);
    vec_t v;
    v.rv = rv; v.ar = ar; v.dv = dv; v.rr = rr; v.d = d;
    v.e_busy = e_busy; v.e_av = e_av; v.e_rdy = e_rdy; v.e_rv = e_rv; v.e_dr = e_dr; v.e_dph = e_dph;
    return v;
  endfunction

  vec_t tbl[10];

  initial begin
    int n0, b0;
    logic [DW-1:0] exp_d[$];
    rst = 1'b1;
    req_valid = '0; req_addr = '0; req_size = '0; rd_ready = '0;
    ddr_in_addr_ready = 0; ddr_in_valid = 0; ddr_in_data = '0;
    auto_drop = 0; busy_cycles = 0;
    model_reset();
    #1 rst = 1'b0;
    // Reset holds every output low even with live inputs
    req_valid = '1; ddr_in_valid = 1; ddr_in_addr_ready = 1; rd_ready = '1; ddr_in_data = 'h55;
    #1 check_zero("reset_async");
    @(posedge clk); @(posedge clk); #1;
    check_zero("reset_clocked");
    req_valid = '0; ddr_in_valid = 0; ddr_in_addr_ready = 0;
    do_reset();

    // --- single request, addr 0x100 size 3, stalls/ignored inputs woven in ---
    tbl[0] = row(3'b001, 1, 1, 3'b111, 'hAA, 0, 0, 3'b000, 3'b000, 0, 0);
    tbl[1] = row(3'b001, 0, 1, 3'b111, 'hAB, 1, 1, 3'b000, 3'b000, 0, 0);
    tbl[2] = row(3'b001, 1, 0, 3'b111, 'hAC, 1, 1, 3'b001, 3'b000, 0, 0);
    tbl[3] = row(3'b000, 0, 1, 3'b111, 'hD0, 1, 0, 3'b000, 3'b001, 1, 1);
    tbl[4] = row(3'b000, 0, 1, 3'b111, 'hD1, 1, 0, 3'b000, 3'b001, 1, 1);
    tbl[5] = row(3'b000, 0, 0, 3'b111, 'hD2, 1, 0, 3'b000, 3'b000, 1, 1);
    tbl[6] = row(3'b000, 0, 1, 3'b110, 'hD2, 1, 0, 3'b000, 3'b001, 0, 1);
    tbl[7] = row(3'b000, 0, 1, 3'b111, 'hD2, 1, 0, 3'b000, 3'b001, 1, 1);
    tbl[8] = row(3'b000, 1, 1, 3'b111, 'hD3, 1, 0, 3'b000, 3'b001, 1, 1);
    tbl[9] = row(3'b000, 1, 1, 3'b111, 'hEE, 0, 0, 3'b000, 3'b000, 0, 0);
    req_addr[0] = 'h100; req_size[0] = 3;
    grant_log.delete(); rx_log.delete();
    for (int r = 0; r < 10; r++) begin
      req_valid = tbl[r].rv; ddr_in_addr_ready = tbl[r].ar; ddr_in_valid = tbl[r].dv;
      rd_ready = tbl[r].rr; ddr_in_data = tbl[r].d;
      #1;
      chk($sformatf("tbl%0d_busy", r), busy, tbl[r].e_busy);
      chk($sformatf("tbl%0d_addr_valid", r), ddr_in_addr_valid, tbl[r].e_av);
      chk($sformatf("tbl%0d_req_ready", r), req_ready, tbl[r].e_rdy);
      chk($sformatf("tbl%0d_rd_valid", r), rd_valid, tbl[r].e_rv);
      chk($sformatf("tbl%0d_ddr_in_ready", r), ddr_in_ready, tbl[r].e_dr);
      if (tbl[r].e_av) begin
        chk($sformatf("tbl%0d_addr", r), ddr_in_addr, 'h100);
        chk($sformatf("tbl%0d_size", r), ddr_in_size, 3);
      end
      if (tbl[r].e_dph) chk($sformatf("tbl%0d_rd_data", r), rd_data, tbl[r].d);
      tick();
    end
    chk("single_addr_hs", grant_log.size(), 1);
    chk("single_beats", beats[0], 4);
    exp_d = '{'hD0, 'hD1, 'hD2, 'hD3};
    chk("single_rx_cnt", rx_log.size(), 4);
    for (int i = 0; i < 4 && i < rx_log.size(); i++) chk($sformatf("single_rx%0d", i), rx_log[i], exp_d[i]);

    // --- contention: all three held from reset release ---
    req_addr[0] = 'h1000; req_addr[1] = 'h1100; req_addr[2] = 'h1200;
    req_size = '{default: BW'(1)};
    req_valid = '1; ddr_in_addr_ready = 1; ddr_in_valid = 1; rd_ready = '1;
    do_reset();
    grant_log.delete();
    for (int c = 0; c < 16; c++) begin
      tick();
      chk($sformatf("contention_busy%0d", c), busy_seen, (c % 4) != 0);
    end
    req_valid = '0;
    chk("contention_grants", grant_log.size(), 4);
    if (grant_log.size() == 4) begin
      chk("contention_g0", grant_log[0], 0);
      chk("contention_g1", grant_log[1], 1);
      chk("contention_g2", grant_log[2], 2);
      chk("contention_g3", grant_log[3], 0);
    end

    // --- backpressure: 8-beat burst to requester 1, rd_ready[1] toggling ---
    auto_drop = 1;
    req_addr[1] = 'h2000; req_size[1] = 7; req_valid = 3'b010;
    ddr_in_data = 'hB0; rx_log.delete(); b0 = beats[1];
    begin
      bit seen, tog, done;
      seen = 0; tog = 1; done = 0;
      for (int c = 0; c < 60 && !done; c++) begin
        rd_ready = {1'b1, tog, 1'b1};
        tog = ~tog;
        tick();
        if (hs_q) ddr_in_data = ddr_in_data + 1;
        if (m_busy) seen = 1;
        else if (seen) done = 1;
      end
      if (!done) begin checks++; failures++; $display("FAIL backpressure_timeout: burst incomplete"); end
    end
    chk("bp_beats", beats[1] - b0, 8);
    chk("bp_rx_cnt", rx_log.size(), 8);
    for (int i = 0; i < 8 && i < rx_log.size(); i++) chk($sformatf("bp_rx%0d", i), rx_log[i], 'hB0 + i);

    // --- address stall: addr_ready low 5 cycles ---
    rd_ready = '1;
    ddr_in_addr_ready = 0; req_addr[2] = 'h2A0; req_size[2] = 1; req_valid = 3'b100;
    n0 = grant_log.size();
    tick();
    for (int c = 0; c < 5; c++) begin
      req_addr[2] = 'hFFF;
      #1;
      chk($sformatf("stall%0d_addr_valid", c), ddr_in_addr_valid, 1);
      chk($sformatf("stall%0d_addr", c), ddr_in_addr, 'h2A0);
      chk($sformatf("stall%0d_req_ready", c), req_ready, 0);
      tick();
    end
    chk("stall_no_hs", grant_log.size(), n0);
    ddr_in_addr_ready = 1;
    run_burst(30);
    chk("stall_hs", grant_log.size(), n0 + 1);
    if (grant_log.size() > n0) chk("stall_grant", grant_log[n0], 2);

    // --- size 0: single beat then straight back to IDLE ---
    req_addr[0] = 'h500; req_size[0] = 0; req_valid = 3'b001;
    b0 = beats[0]; busy_cycles = 0;
    run_burst(20);
    chk("size0_beats", beats[0] - b0, 1);
    chk("size0_busy_cycles", busy_cycles, 2);
`ifdef DDR_ARB_PERF_EN
    for (int i = 0; i < N; i++) chk($sformatf("size0_perf%0d", i), perf_cnt[i], beats[i]);
`endif

    // --- reset mid-burst, then requester 1 wins first ---
    req_addr[0] = 'h300; req_size[0] = 3; req_valid = 3'b001; b0 = beats[0];
    for (int c = 0; c < 20 && (beats[0] - b0) < 2; c++) tick();
    chk("midrst_beats_before", beats[0] - b0, 2);
    rst = 1'b0;
    #1 check_zero("midrst_async");
    @(posedge clk); @(posedge clk); #1;
    check_zero("midrst_clocked");
    req_valid = 3'b010; req_addr[1] = 'h400; req_size[1] = 1;
    model_reset(); grant_log.delete();
    rst = 1'b1;
    run_burst(30);
    chk("midrst_grant_cnt", grant_log.size(), 1);
    if (grant_log.size() > 0) chk("midrst_first_grant", grant_log[0], 1);

    // --- randomized traffic against the model ---
    auto_drop = 0; req_valid = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (acc_q[i]) req_valid[i] = 1'b0;
        else if (!req_valid[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            req_valid[i] = 1'b1;
            req_addr[i] = AW'($urandom);
            req_size[i] = ($urandom_range(0, 4) == 0) ? {BW{1'b1}} : BW'($urandom_range(0, 3));
          end
        end else if (m_busy && !m_addr_done && m_g == i) begin
          if ($urandom_range(0, 7) == 0) req_valid[i] = 1'b0;
          else if ($urandom_range(0, 3) == 0) begin
            req_addr[i] = AW'($urandom);
            req_size[i] = BW'($urandom_range(0, (1 << BW) - 1));
          end
        end
      end
      ddr_in_addr_ready = ($urandom_range(0, 2) != 0);
      ddr_in_valid = ($urandom_range(0, 3) != 0);
      rd_ready = N'($urandom);
      ddr_in_data = DW'($urandom);
      tick();
    end
`ifdef DDR_ARB_PERF_EN
    for (int i = 0; i < N; i++) chk($sformatf("rand_perf%0d", i), perf_cnt[i], beats[i]);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ddr_rd_arbiter.md
DDR_RD_ARBITER -- requirements
Module: ddr_rd_arbiter

Interface
REQ-001 Parameters SHALL be:
- REQ_NUM, default 3, number of read requesters sharing one DDR read channel.
- DDR_W, default GLOBAL_PARAM value, data beat width.
- DDR_ADDR_W, default GLOBAL_PARAM value, address width.
- BURST_W, default GLOBAL_PARAM value, burst-size field width.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock.
- rst, in, 1, reset; asynchronous, active-low.
- req_addr, in, REQ_NUM x DDR_ADDR_W, per-requester burst start address.
- req_size, in, REQ_NUM x BURST_W, per-requester burst length, encoded as beats minus 1.
- req_valid, in, REQ_NUM, per-requester request valid.
- req_ready, out, REQ_NUM, per-requester request accepted.
- rd_data, out, DDR_W, read data, broadcast to all requesters.
- rd_valid, out, REQ_NUM, read data valid, granted requester only.
- rd_ready, in, REQ_NUM, per-requester data ready.
- ddr_in_addr, out, DDR_ADDR_W, DDR read address.
- ddr_in_size, out, BURST_W, DDR burst size.
- ddr_in_addr_valid, out, 1, DDR address valid.
- ddr_in_addr_ready, in, 1, DDR address ready.
- ddr_in_data, in, DDR_W, DDR read data.
- ddr_in_valid, in, 1, DDR read data valid.
- ddr_in_ready, out, 1, DDR read data ready.
- busy, out, 1, high in any state other than IDLE.

Function
REQ-003 The state machine SHALL have exactly three states: IDLE, ADDR, DATA.
REQ-004 IDLE, any req_valid high:
- Grant the first requester with req_valid high, searching round-robin from last_grant+1 (mod REQ_NUM).
- Register that requester's addr and size.
- Go to ADDR next cycle.
REQ-005 IDLE, no req_valid high: remain in IDLE with all handshake outputs low.
REQ-006 ADDR:
- ddr_in_addr_valid = 1; ddr_in_addr/ddr_in_size SHALL be the registered values.
- req_ready[grant] SHALL equal ddr_in_addr_ready, combinationally; all other req_ready bits 0.
- On ddr_in_addr_ready, go to DATA and load beat counter with size.
REQ-007 DATA:
- rd_data = ddr_in_data.
- rd_valid[grant] = ddr_in_valid; all other rd_valid bits 0.
- ddr_in_ready = rd_ready[grant].
- Each beat handshake (ddr_in_valid AND ddr_in_ready) decrements the counter.
- On the handshake with counter == 0, update last_grant to grant and go to IDLE.
REQ-008 Latency: req_valid sampled in IDLE at cycle N SHALL produce ddr_in_addr_valid at N+1. A new request SHALL incur exactly one IDLE bubble cycle after the last beat.
REQ-009 Only one burst SHALL be outstanding; no new address is issued before the current burst's last beat.
REQ-010 Requesters SHALL hold req_valid, req_addr and req_size until req_ready. The arbiter SHALL sample addr/size only in IDLE, so a requester changing its inputs after grant is ignored for that burst.
REQ-011 req_size = 0 SHALL mean a 1-beat burst; req_size = all-ones SHALL mean 2^BURST_W beats. The counter SHALL be BURST_W bits wide and SHALL NOT wrap.
REQ-012 ddr_in_valid outside DATA SHALL be ignored, with ddr_in_ready held 0.
REQ-013 A requester deasserting req_valid while granted in ADDR SHALL NOT cancel the burst; the burst completes.

Reset
REQ-014 While rst is low, regardless of clk, the block SHALL be in the following reset state:
- state = IDLE.
- last_grant = REQ_NUM-1, so requester 0 has first priority.
- All outputs 0.
REQ-015 Reset asserted mid-burst SHALL abandon the burst; no residual rd_valid SHALL appear after release.

Configuration
REQ-016 With DDR_ARB_PERF_EN defined, the block SHALL add output perf_cnt (REQ_NUM x 32) counting beat handshakes per requester, saturating at 2^32-1 and cleared by reset.
REQ-017 Without DDR_ARB_PERF_EN, the perf_cnt port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-018 DDR_W, DDR_ADDR_W and BURST_W SHALL come from GLOBAL_PARAM. The state enum (IDLE/ADDR/DATA) SHALL be a typedef in GLOBAL_PARAM.
REQ-019 The round-robin grant logic SHALL be a sub-module rr_arbiter with inputs req and last, outputs grant index and grant-valid; purely combinational.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Single request: req0 addr=0x100, size=3 -> one address handshake (addr 0x100, size 3), 4 beats on rd_valid[0] only, then busy=0.
- Contention: req0, req1 and req2 all valid and held from reset release -> grant order 0, 1, 2, 0; one IDLE cycle between bursts.
- Backpressure: rd_ready[1] toggling 1010… during 8-beat burst -> ddr_in_ready mirrors it; exactly 8 handshakes; no beat lost or duplicated.
- Address stall: ddr_in_addr_ready held low 5 cycles -> ddr_in_addr_valid stays high, addr stable, req_ready low until handshake.
- Reset mid-burst: rst low after beat 2 of 4 -> all outputs 0 immediately; after release, req1 pending -> granted first.
- Boundary: size=0 -> single beat, return to IDLE; with DDR_ARB_PERF_EN, perf_cnt[grant] increments by exactly the beat count.
